mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_core.sv | 85 ++++++++
 rtl/mdu.sv | 159 +++++++++++++++
 tb/tb_mdu.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and constants for the multiply/divide unit.
//   md_op_e  : MDOp command encodings
//   state_e  : control FSM states
//   MDU_ITER : iterations per mult/div (one result bit per cycle)
//   mag32()  : magnitude of a 32-bit value, optionally treating it as signed
package mdu_pkg;

    localparam int MDU_ITER = 32;
    localparam int CNT_W    = $clog2(MDU_ITER);

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // 0x80000000 negates to itself, which read as unsigned is the correct
    // magnitude, so no 33rd bit is needed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_core.sv
// mdu_core: iterative unsigned datapath shared by multiply and divide.
//   clk, reset_n : clock, async active-low reset
//   start        : load operands, clear accumulator and counter
//   is_div       : 1 = restoring divide, 0 = shift-add multiply
//   opnd         : multiplicand (mult) or divisor (div)
//   ld_lo        : multiplier (mult) or dividend (div), loaded into acc[31:0]
//   step         : perform one iteration this cycle
//   last         : the iteration now pending is the final one
//   acc          : mult -> 64-bit product; div -> {remainder, quotient}
module mdu_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_div,
    input  logic [31:0] opnd,
    input  logic [31:0] ld_lo,
    input  logic        step,
    output logic        last,
    output logic [63:0] acc
);

    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;

        // Multiply: add multiplicand into the upper half when the low
        // multiplier bit is set, then shift the whole 65-bit value right.
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

        // Divide: bring the next dividend bit into the remainder. The
        // remainder stays below the divisor, so the shifted value fits in
        // 33 bits and bit 32 of the difference is a clean borrow flag.
        div_shift = acc_q[63:31];
        div_diff  = div_shift - {1'b0, opnd_q};

        if (start) begin
            acc_d  = {32'd0, ld_lo};
            opnd_d = opnd;
            div_d  = is_div;
            cnt_d  = '0;
        end else if (step) begin
            if (div_q) begin
                if (!div_diff[32]) begin
                    acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                end else begin
                    acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[31:1]};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(MDU_ITER - 1));
    assign acc  = acc_q;

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
//   clk, reset_n : clock, async active-low reset
//   Start        : one-cycle request to execute MDOp
//   MDOp         : MULT/MULTU/DIV/DIVU/MTHI/MTLO, other codes are no-ops
//   A, B         : rs / rt operands
//   Busy         : registered, high while a mult/div is in flight
//   HI, LO       : architectural HI/LO registers
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | accepting commands; launch_q marks the cycle after a mult/div
//        | was accepted, in which the core holds its freshly loaded operands
// S_CALC | core iterating, one bit per cycle for MDU_ITER cycles
// S_FIX  | sign fix-up and HI/LO write, then back to S_IDLE
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_e      state_q, state_d;
    logic        launch_q, launch_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;   // negate product / quotient
    logic        neg_rem_q, neg_rem_d;   // negate remainder (dividend was negative)
    logic        dz_q, dz_d;             // divisor was zero

    logic        signed_op;
    logic        div_op;
    logic        md_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        core_start;
    logic        core_step;
    logic        core_last;
    logic [63:0] core_acc;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign signed_op = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    assign div_op    = (MDOp == MD_DIV)  || (MDOp == MD_DIVU);
    assign md_op     = (MDOp == MD_MULT) || (MDOp == MD_MULTU) || div_op;
    assign a_mag     = mag32(A, signed_op);
    assign b_mag     = mag32(B, signed_op);

    assign prod_fix = neg_res_q ? (64'd0 - core_acc) : core_acc;
    assign quo_fix  = neg_res_q ? (32'd0 - core_acc[31:0]) : core_acc[31:0];
    assign rem_fix  = neg_rem_q ? (32'd0 - core_acc[63:32]) : core_acc[63:32];

    mdu_core u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (core_start),
        .is_div  (div_op),
        .opnd    (div_op ? b_mag : a_mag),
        .ld_lo   (div_op ? a_mag : b_mag),
        .step    (core_step),
        .last    (core_last),
        .acc     (core_acc)
    );

    always_comb begin
        state_d    = state_q;
        launch_d   = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        core_start = 1'b0;
        core_step  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (launch_q) begin
                    state_d = S_CALC;
                end else if (Start) begin
                    if (md_op) begin
                        core_start = 1'b1;
                        launch_d   = 1'b1;
                        is_div_d   = div_op;
                        neg_res_d  = signed_op && (A[31] ^ B[31]);
                        neg_rem_d  = signed_op && A[31];
                        dz_d       = (B == '0);
                    end else if (MDOp == MD_MTHI) begin
                        hi_d = A;
                    end else if (MDOp == MD_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_CALC: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (!dz_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            launch_q  <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            launch_q  <= launch_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors for mdu with a scoreboard queue. Stimulus pushes
// the expected {HI, LO} and the issue edge; a monitor pops on each Busy
// falling edge and checks HI, LO, total latency and Busy length.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          k;
    } exp_t;

    exp_t sbq[$];

    mdu #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Start   (Start),
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: a Busy falling edge is the DUT presenting a result.
    logic prev_busy = 1'b0;
    int   busy_len  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (Busy) busy_len++;
            if (prev_busy && !Busy) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got=1 exp=0");
                end else begin
                    e = sbq.pop_front();
                    check("hi", {32'd0, HI}, {32'd0, e.hi});
                    check("lo", {32'd0, LO}, {32'd0, e.lo});
                    check("latency", 64'(cyc - e.k), 64'd34);
                    check("busy_len", 64'(busy_len), 64'd33);
                end
                busy_len = 0;
            end
            prev_busy = Busy;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit has_result, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        @(negedge clk);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDOp  = 3'b111;
        if (has_result) begin
            e.hi = ehi;
            e.lo = elo;
            e.k  = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sbq.size() != 0 || Busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout got=%0d exp=<100", n);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        Start   = 1'b0;
        MDOp    = 3'b111;
        A       = '0;
        B       = '0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        #19 reset_n = 1'b1;

        issue(MD_MULT,  32'hFFFFFFFD, 32'd5,        1, 32'hFFFFFFFF, 32'hFFFFFFF1); wait_done();
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001); wait_done();
        issue(MD_MULT,  32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000); wait_done();
        issue(MD_DIV,   32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'hFFFFFFFD); wait_done();
        issue(MD_DIV,   32'd7,        32'hFFFFFFFE, 1, 32'h00000001, 32'hFFFFFFFD); wait_done();
        issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000); wait_done();
        issue(MD_DIVU,  32'd7,        32'd2,        1, 32'h00000001, 32'h00000003); wait_done();

        issue(MD_MTHI, 32'h12345678, 32'd0, 0, '0, '0);
        check("mthi_hi", {32'd0, HI}, {32'd0, 32'h12345678});
        check("mthi_lo", {32'd0, LO}, 64'd3);
        check("mthi_busy", {63'd0, Busy}, 64'd0);

        issue(MD_DIVU, 32'd5, 32'd0, 1, 32'h12345678, 32'h00000003); wait_done();

        issue(MD_MTLO, 32'hCAFEF00D, 32'd0, 0, '0, '0);
        check("mtlo_lo", {32'd0, LO}, {32'd0, 32'hCAFEF00D});

        // Commands while busy must be dropped; HI/LO hold until the result.
        issue(MD_MULT, 32'hFFFFFFFE, 32'h10, 1, 32'hFFFFFFFF, 32'hFFFFFFE0);
        repeat (5) @(negedge clk);
        check("busy_mid", {63'd0, Busy}, 64'd1);
        issue(MD_MTLO, 32'hDEADBEEF, 32'd0, 0, '0, '0);
        check("ign_mtlo_lo", {32'd0, LO}, {32'd0, 32'hCAFEF00D});
        check("hold_hi", {32'd0, HI}, {32'd0, 32'h12345678});
        repeat (3) @(negedge clk);
        issue(MD_MULTU, 32'd7, 32'd7, 0, '0, '0);
        wait_done();

        // Asynchronous reset mid-operation discards the in-flight result.
        issue(MD_MULT, 32'h11111111, 32'd3, 1, 32'h0, 32'h33333333);
        repeat (9) @(posedge clk);
        #3 reset_n = 1'b0;
        sbq.delete();
        #1;
        check("arst_busy", {63'd0, Busy}, 64'd0);
        check("arst_hi", {32'd0, HI}, 64'd0);
        check("arst_lo", {32'd0, LO}, 64'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        issue(MD_MULT, 32'd6, 32'd7, 1, 32'h0, 32'd42); wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
